// File: rtl/instr_loader.sv
// instr_loader: packs a valid/ready byte stream little-endian into instruction
// words, writes them to instruction memory from byte address 0 and holds the
// CPU in reset until the image is complete.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (trailing 8-bit checksum byte).
module instr_loader #(
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-2:0] word_count,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     cpu_hold,
   output logic                     csum_err
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned NW    = ADDRESS_WIDTH - 1;
   localparam int unsigned MAXN  = 2 ** (ADDRESS_WIDTH - 2);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHECK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t                   state, state_n;
   logic [ADDRESS_WIDTH-1:0] addr, addr_n, mem_addr_n;
   logic [BW-1:0]            kcnt, kcnt_n;
   logic [DATA_WIDTH-1:0]    shreg, shreg_n, mem_wdata_n;
   logic [NW-1:0]            words, words_n, n, n_n, n_clamp;
   logic                     hs;
   logic                     byte_ready_n, mem_we_n, busy_n, done_n, cpu_hold_n;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]               sum, sum_n;
   logic                     csum_err_n;
`endif

   // Next-state, datapath and registered-output next values
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      kcnt_n      = kcnt;
      shreg_n     = shreg;
      words_n     = words;
      n_n         = n;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_n       = sum;
      csum_err_n  = csum_err;
`endif
      hs      = byte_valid && byte_ready;
      n_clamp = (word_count > NW'(MAXN)) ? NW'(MAXN) : word_count;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               n_n     = n_clamp;
               addr_n  = '0;
               kcnt_n  = '0;
               shreg_n = '0;
               words_n = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
               sum_n      = '0;
               csum_err_n = 1'b0;
`endif
               state_n = (n_clamp == '0) ? S_TAIL : S_LOAD;
            end
         end
         S_LOAD: begin
            if (hs) begin
               shreg_n[{kcnt, 3'b000} +: 8] = byte_data;
               kcnt_n = kcnt + BW'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
               sum_n = sum + byte_data;
`endif
               if (kcnt == BW'(BYTES - 1)) begin
                  state_n     = S_WRITE;
                  mem_addr_n  = addr;
                  mem_wdata_n = shreg_n;
               end
            end
         end
         S_WRITE: begin
            addr_n  = addr + ADDRESS_WIDTH'(BYTES);
            words_n = words + NW'(1);
            state_n = (words_n == n) ? S_TAIL : S_LOAD;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (hs) begin
               csum_err_n = ((sum + byte_data) != 8'd0);
               state_n    = S_DONE;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase

      byte_ready_n = (state_n == S_LOAD) || (state_n == S_CHECK);
      mem_we_n     = (state_n == S_WRITE);
      busy_n       = (state_n == S_LOAD) || (state_n == S_WRITE) || (state_n == S_CHECK);
      done_n       = (state_n == S_DONE);
`ifdef INSTR_LOADER_CHECKSUM_EN
      cpu_hold_n   = (state_n != S_DONE) || csum_err_n;
`else
      cpu_hold_n   = (state_n != S_DONE);
`endif
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         kcnt       <= '0;
         shreg      <= '0;
         words      <= '0;
         n          <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         kcnt       <= kcnt_n;
         shreg      <= shreg_n;
         words      <= words_n;
         n          <= n_n;
         byte_ready <= byte_ready_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         busy       <= busy_n;
         done       <= done_n;
         cpu_hold   <= cpu_hold_n;
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   // Running image checksum and sticky mismatch flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum      <= '0;
         csum_err <= 1'b0;
      end else begin
         sum      <= sum_n;
         csum_err <= csum_err_n;
      end
   end
`else
   assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed test of instr_loader with hand-computed writes.
// Build with +define+INSTR_LOADER_CHECKSUM_EN to cover the checksum variant.
module tb_instr_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, mem_we, busy, done, cpu_hold, csum_err;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;

   int nchecks = 0;
   int nerrs   = 0;
   logic [43:0] wq[$];

   instr_loader dut (
      .clk(clk), .rst(rst), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .cpu_hold(cpu_hold), .csum_err(csum_err)
   );

   always #5 clk = ~clk;

   // Record every memory write strobe (one negedge per WRITE cycle)
   always @(negedge clk) begin
      if (mem_we) wq.push_back({mem_addr, mem_wdata});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [10:0] wc);
      @(negedge clk);
      start      = 1'b1;
      word_count = wc;
      @(negedge clk);
      start      = 1'b0;
   endtask

   // Offer n bytes (byte 0 in bits [7:0]); optionally idle valid between bytes
   task automatic send_bytes(input logic [63:0] b, input int n, input bit toggle);
      for (int i = 0; i < n; i++) begin
         int to = 0;
         byte_valid = 1'b1;
         byte_data  = b[8*i +: 8];
         while (!byte_ready && to < 50) begin
            @(negedge clk);
            to++;
         end
         if (to >= 50) begin
            check("byte_accept_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
            return;
         end
         @(negedge clk);
         byte_valid = 1'b0;
         byte_data  = 8'hFF;
         if (toggle) @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_check_byte(input logic [7:0] cb);
`ifdef INSTR_LOADER_CHECKSUM_EN
      send_bytes(64'(cb), 1, 1'b0);
`else
      cb = cb;
`endif
   endtask

   task automatic wait_done(input string tag);
      int to = 0;
      while (!done && to < 100) begin
         @(negedge clk);
         to++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
      repeat (2) @(negedge clk);
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_mem_we",     32'(mem_we),     32'd0);
      check("rst_mem_addr",   32'(mem_addr),   32'd0);
      check("rst_mem_wdata",  mem_wdata,       32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
      check("rst_csum_err",   32'(csum_err),   32'd0);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_cpu_hold",   32'(cpu_hold),   32'd1);
      check("idle_byte_ready", 32'(byte_ready), 32'd0);
      check("idle_mem_we",     32'(mem_we),     32'd0);
      check("idle_done",       32'(done),       32'd0);

      // Two words, valid held high; check write latency after first word
      wq.delete();
      do_start(11'd2);
      check("load_busy",       32'(busy),       32'd1);
      check("load_byte_ready", 32'(byte_ready), 32'd1);
      send_bytes(64'h0000_0000_0000_0013, 4, 1'b0);
      check("lat_mem_we",     32'(mem_we),   32'd1);
      check("lat_mem_addr",   32'(mem_addr), 32'h000);
      check("lat_mem_wdata",  mem_wdata,     32'h0000_0013);
      check("lat_byte_ready", 32'(byte_ready), 32'd0);
      send_bytes(64'h0000_0000_0010_0093, 4, 1'b0);
      send_check_byte(8'h4A);
      wait_done("t2_done");
      check("t2_nwrites", 32'(wq.size()), 32'd2);
      if (wq.size() == 2) begin
         check("t2_addr0", 32'(wq[0][43:32]), 32'h000);
         check("t2_data0", wq[0][31:0],       32'h0000_0013);
         check("t2_addr1", 32'(wq[1][43:32]), 32'h004);
         check("t2_data1", wq[1][31:0],       32'h0010_0093);
      end
      check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
      check("t2_busy",     32'(busy),     32'd0);
      check("t2_csum_err", 32'(csum_err), 32'd0);

      // Same image with byte_valid toggling, restarted from DONE
      wq.delete();
      do_start(11'd2);
      check("t3_restart_done",     32'(done),     32'd0);
      check("t3_restart_cpu_hold", 32'(cpu_hold), 32'd1);
      send_bytes(64'h0010_0093_0000_0013, 8, 1'b1);
      send_check_byte(8'h4A);
      wait_done("t3_done");
      check("t3_nwrites", 32'(wq.size()), 32'd2);
      if (wq.size() == 2) begin
         check("t3_addr0", 32'(wq[0][43:32]), 32'h000);
         check("t3_data0", wq[0][31:0],       32'h0000_0013);
         check("t3_addr1", 32'(wq[1][43:32]), 32'h004);
         check("t3_data1", wq[1][31:0],       32'h0010_0093);
      end

      // Reset in the middle of a word: no write, state cleared
      wq.delete();
      do_start(11'd2);
      send_bytes(64'h0000_0000_0000_2211, 2, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_mem_we",     32'(mem_we),     32'd0);
      check("mid_rst_mem_addr",   32'(mem_addr),   32'h000);
      check("mid_rst_cpu_hold",   32'(cpu_hold),   32'd1);
      check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_nwrites", 32'(wq.size()), 32'd0);
      check("mid_rst_busy",    32'(busy),      32'd0);
      // Fresh load after reset starts from address 0
      do_start(11'd1);
      send_bytes(64'h0000_0000_DDCC_BBAA, 4, 1'b0);
      send_check_byte(8'hF2);
      wait_done("fresh_done");
      check("fresh_nwrites", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) begin
         check("fresh_addr", 32'(wq[0][43:32]), 32'h000);
         check("fresh_data", wq[0][31:0],       32'hDDCC_BBAA);
      end

      // Zero-word load from IDLE
      pulse_reset();
      wq.delete();
      do_start(11'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
      check("n0_in_check", 32'(byte_ready), 32'd1);
      send_check_byte(8'h00);
`else
      check("n0_done_next", 32'(done), 32'd1);
`endif
      wait_done("n0_done");
      check("n0_nwrites",  32'(wq.size()), 32'd0);
      check("n0_cpu_hold", 32'(cpu_hold),  32'd0);

      // Start from DONE re-asserts cpu_hold; one word with good checksum
      wq.delete();
      do_start(11'd1);
      check("redo_cpu_hold", 32'(cpu_hold), 32'd1);
      check("redo_done",     32'(done),     32'd0);
      send_bytes(64'h0000_0000_0403_0201, 4, 1'b0);
      send_check_byte(8'hF6);
      wait_done("good_done");
      check("good_nwrites",  32'(wq.size()), 32'd1);
      if (wq.size() == 1) check("good_data", wq[0][31:0], 32'h0403_0201);
      check("good_csum_err", 32'(csum_err), 32'd0);
      check("good_cpu_hold", 32'(cpu_hold), 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
      // Bad checksum byte keeps the CPU held
      do_start(11'd1);
      send_bytes(64'h0000_0000_0403_0201, 4, 1'b0);
      send_check_byte(8'hF5);
      wait_done("bad_done");
      check("bad_csum_err", 32'(csum_err), 32'd1);
      check("bad_cpu_hold", 32'(cpu_hold), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction-fetch path.
- Receives a byte stream over a valid/ready handshake and packs it little-endian into DATA_WIDTH words.
- Writes the words sequentially into instruction memory from byte address 0, using the same byte addressing the fetch PC reads.
- Holds the CPU in reset (cpu_hold) until the programmed image is complete.

Parameters:
- ADDRESS_WIDTH, 12, byte-address width of instruction memory.
- DATA_WIDTH, 32, instruction word width; BYTES = DATA_WIDTH/8 (4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately).
- start  input  1  begin a load; sampled only in IDLE or DONE.
- word_count  input  ADDRESS_WIDTH-1  number of words to load; sampled on accepted start.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDRESS_WIDTH  word-aligned byte address (bits [1:0] always 0).
- mem_wdata  output  DATA_WIDTH  packed word.
- busy  output  1  load in progress.
- done  output  1  last load completed.
- cpu_hold  output  1  keep CPU/PC in reset.
- csum_err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold=1, csum_err=0.
- Reset clears all state, including any partial word. No write is issued after rst deasserts.
- IDLE:
  - cpu_hold=1.
  - On start: latch N = min(word_count, 2^(ADDRESS_WIDTH-2)) (1024 at defaults). Clear address, byte counter and words_done.
  - N=0: go directly to DONE.
  - N>0: go to LOAD with busy=1.
- LOAD:
  - byte_ready=1.
  - A handshake occurs when byte_valid && byte_ready at a clock edge.
  - The k-th byte of a word (k=0..3) is stored into shift register bits [8k+7:8k].
  - After the 4th handshake, go to WRITE.
  - byte_data is ignored when byte_valid=0.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_addr=current address, mem_wdata=packed word.
  - Next cycle: address += 4 (wraps modulo 2^ADDRESS_WIDTH; the clamp on N prevents an actual wrap), words_done += 1.
  - If words_done == N, go to DONE; otherwise go to LOAD.
- Latency: mem_we asserts in the cycle immediately after the edge that accepted the 4th byte. Maximum throughput is one word per 5 cycles.
- DONE:
  - done=1, busy=0, cpu_hold=0, byte_ready=0.
  - start in DONE: reload from address 0. done=0 and cpu_hold=1 on the next cycle.
- start while busy is ignored. Bytes offered outside LOAD are not accepted.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Enabled:
  - Running 8-bit sum of all accepted image bytes.
  - After the final WRITE, enter CHECK instead of DONE. CHECK has byte_ready=1 and accepts exactly one extra byte.
  - If (sum + byte) mod 256 != 0: csum_err=1 (held until next start or reset). DONE is still entered, but cpu_hold stays 1.
  - N=0: CHECK is still entered; the check byte must be 0x00.
- Disabled: no CHECK state, csum_err tied 0, timing as described in Behaviour.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, byte_ready=0, mem_we=0, done=0.
- start, word_count=2, bytes 13 00 00 00 93 00 10 00 with valid held high -> writes addr 0x000 data 0x00000013, addr 0x004 data 0x00100093; done=1, cpu_hold=0.
- Same load with byte_valid toggling 1/0 each cycle -> identical writes; no handshake while valid=0; mem_we never asserts twice for one word.
- start, word_count=0 -> DONE next cycle, zero writes; start again while in DONE -> cpu_hold returns to 1.
- rst pulled low after 2 bytes of word 1, then released -> no write, mem_addr=0; a fresh start loads correctly from 0x000.
- With INSTR_LOADER_CHECKSUM_EN: 1 word 01 02 03 04, check byte 0xF6 -> csum_err=0, cpu_hold=0. Check byte 0xF5 -> csum_err=1, cpu_hold=1.
